// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing for the sequential multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned CNT_W    = $clog2(MD_WIDTH);

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ABS  = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } md_state_t;

endpackage

// File: rtl/muldiv_if.sv
// Pipeline-to-muldiv request/result bundle.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_addsub.sv
// Shared add/subtract unit; carry or borrow appears in the MSB of sum.
module muldiv_addsub #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum
);

  // Subtract as x + ~y + 1.
  always_comb begin
    sum = x + (y ^ {W{sub}}) + {{(W-1){1'b0}}, sub};
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: shift-add multiply and
// restoring divide over WIDTH iterations on one shared add/sub unit.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic     clk,
  input  logic     resetn,
  muldiv_if.slave  bus
);

  md_state_t        state, state_nxt;
  md_op_t           op_r;
  logic [WIDTH-1:0] a_r;      // original a, then |a| (multiplicand)
  logic [WIDTH-1:0] b_r;      // original b, then |b| (multiplier / divisor)
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic [WIDTH:0]   au_x;
  logic [WIDTH:0]   au_y;
  logic             au_sub;
  logic [WIDTH:0]   au_sum;

  logic             is_mul;
  logic             accept;
  logic             last_iter;
  logic             div_ge;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic [2*WIDTH-1:0] prod;

  assign is_mul    = (op_r == MD_MULT) || (op_r == MD_MULTU);
  assign accept    = (state == IDLE) && bus.start && !bus.flush;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
    .x   (au_x),
    .y   (au_y),
    .sub (au_sub),
    .sum (au_sum)
  );

  // Steer the shared adder: negate a in ABS, add or trial-subtract in ITER.
  always_comb begin
    au_x   = '0;
    au_y   = '0;
    au_sub = 1'b0;
    if (state == ABS) begin
      au_y   = {1'b0, a_r};
      au_sub = 1'b1;
    end else if (state == ITER) begin
      if (is_mul) begin
        au_x = {1'b0, acc_hi};
        au_y = b_r[0] ? {1'b0, a_r} : '0;
      end else begin
        au_x   = {acc_hi, acc_lo[WIDTH-1]};
        au_y   = {1'b0, b_r};
        au_sub = 1'b1;
      end
    end
  end

  // The shifted partial remainder is 33 bits wide, so when its top bit is set
  // it already exceeds any divisor and the borrow bit alone cannot be trusted.
  assign div_ge = au_x[WIDTH] | ~au_sum[WIDTH];

  // Sign correction of the final magnitudes.
  always_comb begin
    prod   = {acc_hi, acc_lo};
    fix_hi = acc_hi;
    fix_lo = acc_lo;
    if (is_mul) begin
      if (sign_a ^ sign_b) prod = -prod;
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else begin
      if (sign_a ^ sign_b) fix_lo = -acc_lo;
      if (sign_a)          fix_hi = -acc_hi;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; flush returns any active state to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = ABS;
      ABS:  state_nxt = ITER;
      ITER: if (last_iter) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush && state != IDLE) state_nxt = IDLE;
  end

  // Operand capture, magnitude conversion, iteration and result commit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_r   <= MD_MULT;
      a_r    <= '0;
      b_r    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r   <= md_op_t'(bus.op);
            a_r    <= bus.a;
            b_r    <= bus.b;
            sign_a <= (bus.op == MD_MULT || bus.op == MD_DIV) && bus.a[WIDTH-1];
            sign_b <= (bus.op == MD_MULT || bus.op == MD_DIV) && bus.b[WIDTH-1];
          end
        end
        ABS: begin
          cnt    <= '0;
          acc_hi <= '0;
          acc_lo <= '0;
          // Divide by zero keeps a unsigned and skips sign fix so the
          // iteration leaves quotient all-ones and remainder equal to a.
          if (!is_mul && b_r == '0) begin
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            acc_lo <= a_r;
          end else begin
            if (sign_a) a_r <= au_sum[WIDTH-1:0];
            if (sign_b) b_r <= -b_r;
            if (!is_mul) acc_lo <= sign_a ? au_sum[WIDTH-1:0] : a_r;
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (is_mul) begin
            acc_hi <= au_sum[WIDTH:1];
            acc_lo <= {au_sum[0], acc_lo[WIDTH-1:1]};
            b_r    <= b_r >> 1;
          end else begin
            acc_hi <= div_ge ? au_sum[WIDTH-1:0] : {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end
        end
        FIX: begin
          if (!bus.flush) begin
            hi_r <= fix_hi;
            lo_r <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: the corrected result is presented during FIX alongside done.
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == FIX) && !bus.flush;
    bus.hi   = bus.done ? fix_hi : hi_r;
    bus.lo   = bus.done ? fix_lo : lo_r;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with hand-computed results.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic resetn;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller sits at a negedge; returns at the negedge of cycle 1.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Starts at the negedge of cycle 1, returns at the negedge where done is seen.
  // inj > 0 pulses a spurious start during that cycle.
  task automatic wait_done(input int inj, output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (lat <= 100) begin
      if (bus.busy === 1'b1) bcnt++;
      if (bus.done === 1'b1) break;
      if (lat == inj) begin
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.a     = 32'd7;
        bus.b     = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    if (lat > 100) lat = -1;
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int lat, bcnt;
    launch(op, a, b);
    wait_done(0, lat, bcnt);
    chk({tag, "_latency"}, 32'(lat), 32'd34);
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd34);
    chk({tag, "_hi"}, bus.hi, ehi);
    chk({tag, "_lo"}, bus.lo, elo);
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done_after"}, 32'(bus.done), 32'd0);
    chk({tag, "_lo_hold"}, bus.lo, elo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt, ndone;
    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'd0;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    run("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run("mult_neg3x7", 2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("div_neg7by2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_7byneg2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run("mult_minsq", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

    // Divide by zero with a start pulsed mid-operation and one in the done cycle.
    launch(2'd3, 32'd100, 32'd0);
    wait_done(5, lat, bcnt);
    chk("divz_latency", 32'(lat), 32'd34);
    chk("divz_hi", bus.hi, 32'h0000_0064);
    chk("divz_lo", bus.lo, 32'hFFFF_FFFF);
    bus.start = 1'b1;
    bus.op    = 2'd1;
    bus.a     = 32'd2;
    bus.b     = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_in_done_ignored", 32'(bus.busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("no_second_done", 32'(ndone), 32'd0);
    chk("divz_hi_hold", bus.hi, 32'h0000_0064);

    run("multu_5x6", 2'd1, 32'd5, 32'd6, 32'd0, 32'd30);

    // Flush at cycle 10 of a DIVU.
    launch(2'd3, 32'd9, 32'd3);
    ndone = 0;
    repeat (9) begin
      if (bus.done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("flush_busy_c10", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    if (bus.done === 1'b1) ndone++;
    chk("flush_busy_c11", 32'(bus.busy), 32'd0);
    chk("flush_no_done", 32'(ndone), 32'd0);
    chk("flush_hi_hold", bus.hi, 32'd0);
    chk("flush_lo_hold", bus.lo, 32'd30);
    run("divu_9by3", 2'd3, 32'd9, 32'd3, 32'd0, 32'd3);

    // Asynchronous reset in cycle 20 of a MULT.
    launch(2'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    repeat (19) @(negedge clk);
    chk("prereset_busy", 32'(bus.busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_done", 32'(bus.done), 32'd0);
    chk("async_rst_hi", bus.hi, 32'd0);
    chk("async_rst_lo", bus.lo, 32'd0);
    #1 resetn = 1'b1;
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.a     = 32'hFFFF_FFFD;
    bus.b     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    chk("post_rst_accept", 32'(bus.busy), 32'd1);
    wait_done(0, lat, bcnt);
    chk("post_rst_latency", 32'(lat), 32'd34);
    chk("post_rst_hi", bus.hi, 32'hFFFF_FFFF);
    chk("post_rst_lo", bus.lo, 32'hFFFF_FFEB);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the MIPS core's execute stage. It drives one shared 33-bit add/subtract unit through 32 shift-add or restoring-subtract iterations and writes the HI/LO result pair. The pipeline stalls on `busy` and samples `hi`/`lo` when `done` pulses.

## Interface
- `WIDTH`, 32, operand width; iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  operation request; accepted only in IDLE.
- `op`  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with `start`.
- `a`  in  WIDTH  multiplicand or dividend (rs); sampled with `start`.
- `b`  in  WIDTH  multiplier or divisor (rt); sampled with `start`.
- `flush`  in  1  cancels an in-flight operation (exception or branch squash).
- `busy`  out  1  high from the cycle after acceptance until `done`, inclusive.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid in the same cycle.
- `hi`  out  WIDTH  product high word, or remainder.
- `lo`  out  WIDTH  product low word, or quotient.

## Operation
- States: IDLE → ABS → ITER → FIX → IDLE.
- **IDLE:** `start=1` and `flush=0` latches `op`, `a`, `b`, sign_a and sign_b. Signs are zero for MULTU/DIVU. Go to ABS.
- **ABS (1 cycle):** replace each signed operand with its magnitude (two's-complement negate if its sign is set). Clear the 2·WIDTH accumulator `{acc_hi, acc_lo}`. Set `acc_lo` = |a| for divide, and set the multiplier register = |b| for multiply.
- **ITER (WIDTH cycles, counter 0..WIDTH-1):**
  - Multiply: if multiplier LSB is 1, acc_hi += |a| using the 33-bit add to keep the carry. Then shift {carry, acc_hi, acc_lo} right by 1 and shift the multiplier right by 1.
  - Divide: shift {acc_hi, acc_lo} left by 1, then compute acc_hi − |b| on the 33-bit unit. If the result is non-negative, acc_hi = difference and acc_lo[0] = 1; otherwise acc_hi is unchanged and acc_lo[0] = 0.
- **FIX (1 cycle):**
  - Multiply: negate the 64-bit product if sign_a ^ sign_b.
  - Divide: negate the quotient if sign_a ^ sign_b, and negate the remainder if sign_a.
  - Register the results into `hi`/`lo`, pulse `done`, and return to IDLE.
- **Divide by zero (b==0):** same latency. Result is `lo`=32'hFFFF_FFFF and `hi`=`a` (original, unsigned-interpreted). The iteration produces this naturally; the signed fix is suppressed when b==0.
- **Overflow:** DIV 0x8000_0000 / 0xFFFF_FFFF gives `lo`=0x8000_0000 and `hi`=0, with no trap.
- **Arithmetic:** all magnitudes are unsigned WIDTH bits, and |0x8000_0000| = 0x8000_0000. The add/sub unit is 33 bits wide and its carry/borrow is its MSB.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state=IDLE, counter=0.
- With `start` accepted at edge 0: ABS at cycle 1, ITER at cycles 2–33, FIX at cycle 34. `done` is high in cycle 34 (registered) and `busy` is high in cycles 1–34.
- Total latency is WIDTH+2 cycles for every op and every operand value; there is no early termination.
- `start` while `busy` is ignored; no queueing.
- `start` in the same cycle as `done`: ignored. A new start is accepted the following cycle at the earliest.
- `flush` in any non-IDLE state: next state is IDLE, `busy` drops next cycle, no `done`, and `hi`/`lo` keep their previous values.
- `flush` in IDLE with `start`: `flush` wins and nothing is accepted.
- `flush` in the FIX cycle: the result is discarded and `done` is suppressed.
- `resetn` low mid-operation: all outputs go to reset values immediately (asynchronously), and the operation is lost.
- `hi`/`lo` change only in the FIX cycle or on reset.

## Structure
- `muldiv_pkg` holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - the state encoding (IDLE, ABS, ITER, FIX);
  - the iteration-counter width, $clog2(WIDTH).
- Sub-module `muldiv_addsub` (33-bit, inputs `x`, `y`, `sub`; output `sum[32:0]`): a single instance shared by ABS negation and ITER.
- FIX negation uses dedicated logic: 64-bit for multiply, two independent 32-bit negates for divide.
- Top level contains the FSM, counter, operand registers and accumulator.

## Test plan
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF → `done` 34 cycles after acceptance; `hi`=0xFFFF_FFFE, `lo`=0x0000_0001.
- MULT a=0xFFFF_FFFD (−3), b=7 → `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFEB; `busy` high exactly 34 cycles.
- DIV a=0xFFFF_FFF9 (−7), b=2 → `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF. Then DIV 0x8000_0000 / 0xFFFF_FFFF → `lo`=0x8000_0000, `hi`=0.
- DIVU a=100, b=0 → `lo`=0xFFFF_FFFF, `hi`=0x0000_0064. A `start` pulsed during `busy` is ignored and produces no second `done`.
- MULTU 5×6 completes (`lo`=30). Then start DIVU 9/3 and assert `flush` at cycle 10 → no `done`, `busy`=0 from cycle 11, `hi`/`lo` stay 0/30. A new start at cycle 12 completes normally.
- `resetn` low at cycle 20 of a MULT → `busy`/`done`/`hi`/`lo` go to 0 without a clock edge. After release, IDLE accepts `start` on the next edge.
